rr_priority_encoder: RTL and testbench
======================================

Name: rr_priority_encoder

Overview:
Parametrised N-to-log2(N) priority encoder with a registered output and a valid/ready handshake. It generalises the fixed 16x4 encoder to any N. It adds a round-robin mode, in which a rotating priority pointer gives fair selection among simultaneous requests. It sits between request sources and consumers such as arbiters and interrupt steering, at one result per cycle.

Parameters:
N, 16, number of request lines; must be at least 2 and a power of 2
W, $clog2(N), width of the encoded index (derived; not overridden)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
en  input  1  encoder enable, sampled together with req on accept
mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin
req  input  N  request vector
in_valid  input  1  req, en and mode are valid
in_ready  output  1  block can accept a request this cycle
out_valid  output  1  result registers hold a valid result
out_ready  input  1  consumer takes the result
y  output  W  encoded index of the winner
found  output  1  at least one request bit was selected
grant  output  N  one-hot winner; all zero when found=0

Behaviour:
- All state changes on the rising edge of clk. Reset is synchronous: sampled only at the edge.
- Reset values (rst_n=0 at an edge): out_valid=0, y=0, found=0, grant=0, ptr=0.
- Reset mid-operation: any pending result is discarded, and the input presented in that cycle is not accepted.
- in_ready = !out_valid || out_ready. It is combinational and does not depend on in_valid.
- Accept: in_valid && in_ready at an edge.
  - The result appears in y/found/grant with out_valid=1 after that edge (latency 1).
  - Throughput is 1 per cycle: a pop and a new accept in the same cycle give back-to-back results.
- Pop without accept (out_valid && out_ready && !in_valid): out_valid clears to 0. y, found and grant hold their last value.
- Hold: while out_valid && !out_ready, y, found and grant are stable and no new accept occurs.
- en=0 on accept: a result is still produced with out_valid=1, found=0, y=0, grant=0. ptr is unchanged.
- req=0 on accept: found=0, y=0, grant=0. ptr is unchanged.
- Fixed mode (mode=0): the highest set index wins. ptr is not read or modified.
- Round-robin mode (mode=1):
  - Search starts at index ptr and goes upward, wrapping from N-1 to 0. The first set bit wins.
  - On an accepted result with found=1: ptr <= (winner + 1) mod N, using W-bit natural wrap.
- ptr is updated only on accept, never on pop.
- mode may change on any accept. ptr keeps its value across fixed-mode periods.
- Arithmetic: all index arithmetic is W bits wide and wraps modulo N. There are no out-of-range indices.
- No combinational path from req, en or mode to any output. The only combinational path is out_ready -> in_ready.

Decomposition:
- Package enc_pkg:
  - constants MODE_FIXED=1'b0 and MODE_RR=1'b1
  - function clog2 for W derivation
- One sub-module, rr_pick, which is purely combinational.
  - Inputs: req[N-1:0], ptr[W-1:0], mode.
  - Outputs: idx[W-1:0], hit, onehot[N-1:0].
  - Implements both searches, using a double-width rotate for the round-robin case.
- The top level holds the handshake, result registers and ptr.

Test Plan:
1. Reset: rst_n=0 for 2 edges while in_valid=1, req=16'hFFFF -> out_valid=0, y=0, found=0, grant=0, in_ready=1. After release the first accept yields y=15 (mode=0).
2. Fixed walking-one: mode=0, en=1, out_ready=1, req=16'h0002, 0004, ... 0200 on consecutive cycles -> y=1..9, each one cycle after accept, found=1, grant equal to req. Then req=16'h8001 -> y=15.
3. Round-robin fairness and wrap:
   - mode=1, ptr=0, req=16'h8001 three times -> y=0, 15, 0.
   - Force ptr=15 via a grant at 14, then req=16'h0003 -> y=0, and ptr becomes 1.
4. Disable and empty: en=0 with req=16'hFFFF -> out_valid=1, found=0, y=0. Then en=1 with req=0 -> found=0. ptr is unchanged after both (checked by a following round-robin result).
5. Backpressure: hold out_ready=0 after one result -> in_ready=0, and y/found/grant are stable for 5 cycles despite req changes. Assert out_ready with in_valid=1 -> the held result is popped and the new result appears on the next edge with no gap.
6. Reset mid-stream: mode=1 with out_valid=1 and ptr=5, then rst_n=0 for one edge -> out_valid=0, ptr=0. The next req=16'h0021 in mode=1 gives y=0.

Source files
------------

// File: rtl/rr_priority_encoder_pkg.sv
// Shared constants and helpers for the round-robin priority encoder.
//   MODE_FIXED / MODE_RR : values of the mode input
//   clog2()              : index width derivation for a request vector of N lines
package enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_encoder_if.sv
// Request/result bus of the priority encoder.
//   en, mode, req, in_valid : request side (driven by master)
//   in_ready                : encoder can accept a request
//   out_valid, y, found,
//   grant                   : registered result (driven by slave)
//   out_ready               : consumer takes the result (driven by master)
interface rr_priority_encoder_if
  import enc_pkg::*;
#(
  parameter int unsigned N = 16
);
  localparam int unsigned W = clog2(N);

  logic         en;
  logic         mode;
  logic [N-1:0] req;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         found;
  logic [N-1:0] grant;

  modport master (
    output en, mode, req, in_valid, out_ready,
    input  in_ready, out_valid, y, found, grant
  );

  modport slave (
    input  en, mode, req, in_valid, out_ready,
    output in_ready, out_valid, y, found, grant
  );

endinterface

// File: rtl/rr_priority_encoder_rr_pick.sv
// Combinational winner selection.
//   req    : request vector
//   ptr    : round-robin start index (ignored in fixed mode)
//   mode   : MODE_FIXED = highest index wins, MODE_RR = first set bit at/after ptr
//   idx    : winning index (0 when no hit)
//   hit    : at least one request set
//   onehot : one-hot winner (all zero when no hit)
module rr_pick
  import enc_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic         hit,
  output logic [N-1:0] onehot
);

  // Rotating {req,req} right by ptr puts index (ptr+k) mod N at bit k,
  // so the lowest set bit of the low half is the round-robin winner.
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;

  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[N-1:0];

  always_comb begin
    idx    = '0;
    hit    = 1'b0;
    onehot = '0;
    if (mode == MODE_RR) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (!hit && w_rot[k]) begin
          hit = 1'b1;
          idx = ptr + W'(k);
        end
      end
    end else begin
      // Ascending scan; the last set bit seen is the highest index.
      for (int unsigned i = 0; i < N; i++) begin
        if (req[i]) begin
          hit = 1'b1;
          idx = W'(i);
        end
      end
    end
    if (hit) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_priority_encoder.sv
// N-to-log2(N) priority encoder with registered result, valid/ready handshake
// and an optional round-robin mode driven by a rotating priority pointer.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : request/result bus (slave side), see rr_priority_encoder_if
module rr_priority_encoder
  import enc_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  rr_priority_encoder_if.slave bus
);

  localparam int unsigned W = clog2(N);

  logic         r_out_valid;
  logic [W-1:0] r_y;
  logic         r_found;
  logic [N-1:0] r_grant;
  logic [W-1:0] r_ptr;

  logic         w_accept;
  logic [W-1:0] w_idx;
  logic         w_hit;
  logic [N-1:0] w_onehot;

  rr_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .req    (bus.req),
    .ptr    (r_ptr),
    .mode   (bus.mode),
    .idx    (w_idx),
    .hit    (w_hit),
    .onehot (w_onehot)
  );

  assign bus.in_ready  = !r_out_valid || bus.out_ready;
  assign w_accept      = bus.in_valid && bus.in_ready;

  assign bus.out_valid = r_out_valid;
  assign bus.y         = r_y;
  assign bus.found     = r_found;
  assign bus.grant     = r_grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_found     <= 1'b0;
      r_grant     <= '0;
      r_ptr       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      if (bus.en) begin
        r_y     <= w_idx;
        r_found <= w_hit;
        r_grant <= w_onehot;
        // Pointer moves past the winner only for a real round-robin grant.
        if (w_hit && (bus.mode == MODE_RR)) r_ptr <= w_idx + W'(1);
      end else begin
        r_y     <= '0;
        r_found <= 1'b0;
        r_grant <= '0;
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_priority_encoder.sv
module tb_rr_priority_encoder;
  import enc_pkg::*;

  logic clk;
  logic rst_n;
  int unsigned n_cmp;
  int unsigned n_err;

  rr_priority_encoder_if #(.N(16)) bus ();

  rr_priority_encoder #(.N(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] r, input logic e, input logic m);
    bus.req      = r;
    bus.en       = e;
    bus.mode     = m;
    bus.in_valid = 1'b1;
  endtask

  task automatic chk_res(input string tag, input logic [3:0] ey, input logic ef,
                         input logic [15:0] eg);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".y"},     32'(bus.y),         32'(ey));
    chk({tag, ".found"}, 32'(bus.found),     32'(ef));
    chk({tag, ".grant"}, 32'(bus.grant),     32'(eg));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset with a request pending: nothing accepted.
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    drive(16'hFFFF, 1'b1, MODE_FIXED);
    step();
    step();
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.y",     32'(bus.y),         32'd0);
    chk("rst.found", 32'(bus.found),     32'd0);
    chk("rst.grant", 32'(bus.grant),     32'd0);
    chk("rst.ready", 32'(bus.in_ready),  32'd1);
    rst_n = 1'b1;
    step();
    chk_res("first", 4'd15, 1'b1, 16'h8000);

    // Fixed walking-one.
    for (int i = 1; i <= 9; i++) begin
      drive(16'(1) << i, 1'b1, MODE_FIXED);
      step();
      chk_res($sformatf("walk%0d", i), 4'(i), 1'b1, 16'(1) << i);
    end
    drive(16'h8001, 1'b1, MODE_FIXED);
    step();
    chk_res("fix8001", 4'd15, 1'b1, 16'h8000);

    // Round-robin: ptr 0 -> 1 -> 0 -> 1.
    drive(16'h8001, 1'b1, MODE_RR);
    step(); chk_res("rr0", 4'd0,  1'b1, 16'h0001);
    step(); chk_res("rr1", 4'd15, 1'b1, 16'h8000);
    step(); chk_res("rr2", 4'd0,  1'b1, 16'h0001);
    // Grant 14 -> ptr 15; then wrap to 0 -> ptr 1; then 1 -> ptr 2.
    drive(16'h4000, 1'b1, MODE_RR);
    step(); chk_res("rr14", 4'd14, 1'b1, 16'h4000);
    drive(16'h0003, 1'b1, MODE_RR);
    step(); chk_res("rrwrap", 4'd0, 1'b1, 16'h0001);
    step(); chk_res("rrptr1", 4'd1, 1'b1, 16'h0002);

    // Disable and empty; ptr stays 2.
    drive(16'hFFFF, 1'b0, MODE_RR);
    step(); chk_res("dis", 4'd0, 1'b0, 16'h0000);
    drive(16'h0000, 1'b1, MODE_RR);
    step(); chk_res("empty", 4'd0, 1'b0, 16'h0000);
    drive(16'h0005, 1'b1, MODE_RR);
    step(); chk_res("ptrkeep", 4'd2, 1'b1, 16'h0004);

    // Backpressure.
    drive(16'h0010, 1'b1, MODE_FIXED);
    step(); chk_res("bp0", 4'd4, 1'b1, 16'h0010);
    bus.out_ready = 1'b0;
    #1;
    chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      drive(16'h0100 << c, 1'b1, MODE_FIXED);
      step();
      chk_res($sformatf("hold%0d", c), 4'd4, 1'b1, 16'h0010);
    end
    drive(16'h0100, 1'b1, MODE_FIXED);
    bus.out_ready = 1'b1;
    #1;
    chk("bp.ready_on", 32'(bus.in_ready), 32'd1);
    step(); chk_res("b2b", 4'd8, 1'b1, 16'h0100);
    // Pop without accept: valid clears, result holds.
    bus.in_valid = 1'b0;
    step();
    chk("pop.valid", 32'(bus.out_valid), 32'd0);
    chk("pop.y",     32'(bus.y),         32'd8);
    chk("pop.grant", 32'(bus.grant),     32'h0100);

    // Reset mid-stream with ptr=5.
    drive(16'h0010, 1'b1, MODE_RR);
    step(); chk_res("ptr5", 4'd4, 1'b1, 16'h0010);
    rst_n = 1'b0;
    drive(16'hFFFF, 1'b1, MODE_RR);
    step();
    chk("mrst.valid", 32'(bus.out_valid), 32'd0);
    chk("mrst.y",     32'(bus.y),         32'd0);
    rst_n = 1'b1;
    drive(16'h0021, 1'b1, MODE_RR);
    step(); chk_res("mrst.rr", 4'd0, 1'b1, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
